// File: rtl/arb_pops_n.sv
// Pop arbiter between NUM_VC source FIFOs: strict-priority or burst-limited round-robin,
// stalled by any destination pause plus a programmable resume holdoff.
module arb_pops_n #(
   parameter int NUM_VC     = 2,
   parameter int NUM_DEST   = 2,
   parameter int MODE       = 0,
   parameter int BURST      = 4,
   parameter int RESUME_DLY = 0,
   parameter int IDX_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_VC-1:0]   vc_empty,
   input  logic [NUM_DEST-1:0] dest_pause,
   output logic [NUM_VC-1:0]   vc_pop,
   output logic [NUM_VC-1:0]   pop_delay,
   output logic [IDX_W-1:0]    grant_idx,
   output logic                grant_valid,
   output logic [IDX_W-1:0]    grant_idx_d
);

   logic [NUM_VC-1:0] req;
   logic [IDX_W-1:0]  rr_owner;
   logic [7:0]        burst_cnt;
   logic [7:0]        hold_cnt;
   logic              stall;
   logic              keep;
   logic              win_found;
   logic [IDX_W-1:0]  win_idx;
   logic              pop_en;
   logic [NUM_VC-1:0] pop_p1;
   logic [IDX_W-1:0]  idx_p1;

   assign req   = ~vc_empty;
   assign stall = (|dest_pause) | (hold_cnt != 8'd0);

   // Stage 0: winner selection; the search runs from the farthest offset down so the nearest wins
   always_comb begin : sel_comb
      int               s;
      logic [IDX_W-1:0] cand;
      s         = 0;
      cand      = '0;
      keep      = 1'b0;
      win_found = 1'b0;
      win_idx   = '0;
      if (MODE == 0) begin
         for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (req[i]) begin
               win_found = 1'b1;
               win_idx   = IDX_W'(i);
            end
         end
      end else begin
         keep = req[rr_owner] && (burst_cnt < 8'(BURST));
         for (int k = NUM_VC; k >= 1; k--) begin
            s = int'(rr_owner) + k;
            if (s >= NUM_VC) s = s - NUM_VC;
            cand = IDX_W'(s);
            if (req[cand]) begin
               win_found = 1'b1;
               win_idx   = cand;
            end
         end
         if (keep) begin
            win_found = 1'b1;
            win_idx   = rr_owner;
         end
      end
   end

   assign pop_en      = win_found & ~stall & ~reset;
   assign vc_pop      = pop_en ? (NUM_VC'(1) << win_idx) : '0;
   assign grant_idx   = pop_en ? win_idx : '0;
   assign grant_valid = |vc_pop;

   // Stage 0 -> 1: arbitration state and holdoff
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_owner  <= '0;
         burst_cnt <= 8'd0;
         hold_cnt  <= 8'd0;
      end else begin
         if (|dest_pause) begin
            hold_cnt <= 8'(RESUME_DLY);
         end else if (hold_cnt != 8'd0) begin
            hold_cnt <= hold_cnt - 8'd1;
         end
         if ((MODE != 0) && pop_en) begin
            if (keep) begin
               burst_cnt <= burst_cnt + 8'd1;
            end else begin
               rr_owner  <= win_idx;
               burst_cnt <= 8'd1;
            end
         end
      end
   end

   // Stage 1: delayed copy for the downstream mux; vc_pop is forced low during reset, so these clear too
   always_ff @(posedge clk) begin
      pop_p1 <= vc_pop;
      idx_p1 <= grant_idx;
   end

   assign pop_delay   = pop_p1;
   assign grant_idx_d = idx_p1;

endmodule

// File: tb/tb_arb_pops_n.sv
// Bench for arb_pops_n: three configurations share one stimulus stream and are checked
// every cycle against a behavioural model, with literal expectations on directed phases.
module tb_arb_pops_n;

   logic       clk;
   logic       reset;
   logic [3:0] empty;
   logic [1:0] pause;
   logic       done;

   logic [3:0] pop0, pd0;
   logic [2:0] pop1, pd1, pop2, pd2;
   logic [1:0] gi0, gid0, gi1, gid1, gi2, gid2;
   logic       gv0, gv1, gv2;

   int errors;
   int checks;

   localparam int NVC[3]   = '{4, 3, 3};
   localparam int MD[3]    = '{1, 0, 1};
   localparam int BST[3]   = '{2, 4, 3};
   localparam int RDLY[3]  = '{3, 0, 0};

   int m_owner[3];
   int m_cnt[3];
   int m_hold[3];
   int m_prev[3];
   bit prev_known;

   arb_pops_n #(.NUM_VC(4), .NUM_DEST(2), .MODE(1), .BURST(2), .RESUME_DLY(3)) u0 (
      .clk(clk), .reset(reset), .vc_empty(empty), .dest_pause(pause),
      .vc_pop(pop0), .pop_delay(pd0), .grant_idx(gi0), .grant_valid(gv0), .grant_idx_d(gid0));

   arb_pops_n #(.NUM_VC(3), .NUM_DEST(2), .MODE(0), .BURST(4), .RESUME_DLY(0)) u1 (
      .clk(clk), .reset(reset), .vc_empty(empty[2:0]), .dest_pause(pause),
      .vc_pop(pop1), .pop_delay(pd1), .grant_idx(gi1), .grant_valid(gv1), .grant_idx_d(gid1));

   arb_pops_n #(.NUM_VC(3), .NUM_DEST(2), .MODE(1), .BURST(3), .RESUME_DLY(0)) u2 (
      .clk(clk), .reset(reset), .vc_empty(empty[2:0]), .dest_pause(pause),
      .vc_pop(pop2), .pop_delay(pd2), .grant_idx(gi2), .grant_valid(gv2), .grant_idx_d(gid2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int k, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL u%0d %s got=%0d expected=%0d at %0t", k, nm, act, exp, $time);
      end
   endtask

   // Behavioural model: returns this cycle's winner (-1 = none) and advances state to the next cycle
   task automatic model_cycle(input int k, input logic r, input logic [3:0] e, input logic [1:0] p,
                              output int win);
      bit stall;
      bit keep;
      int idx;
      win   = -1;
      keep  = 0;
      stall = (p != 2'b00) || (m_hold[k] != 0);
      if (!r && !stall) begin
         if (MD[k] == 0) begin
            for (int i = NVC[k] - 1; i >= 0; i--) if (!e[i]) win = i;
         end else if (!e[m_owner[k]] && m_cnt[k] < BST[k]) begin
            win  = m_owner[k];
            keep = 1;
         end else begin
            for (int off = NVC[k]; off >= 1; off--) begin
               idx = (m_owner[k] + off) % NVC[k];
               if (!e[idx]) win = idx;
            end
         end
      end
      if (r) begin
         m_owner[k] = 0;
         m_cnt[k]   = 0;
         m_hold[k]  = 0;
      end else begin
         if (p != 2'b00) m_hold[k] = RDLY[k];
         else if (m_hold[k] != 0) m_hold[k] = m_hold[k] - 1;
         if (MD[k] != 0 && win >= 0) begin
            if (keep) m_cnt[k] = m_cnt[k] + 1;
            else begin
               m_owner[k] = win;
               m_cnt[k]   = 1;
            end
         end
      end
      m_prev[k] = win;
   endtask

   task automatic cmp_inst(input int k, input int pop, input int pd, input int gi, input int gid,
                           input int gv, input logic [3:0] e);
      int win;
      int pw;
      pw = m_prev[k];
      model_cycle(k, reset, e, pause, win);
      check("vc_pop", k, pop, (win >= 0) ? (1 << win) : 0);
      check("grant_idx", k, gi, (win >= 0) ? win : 0);
      check("grant_valid", k, gv, (win >= 0) ? 1 : 0);
      if (prev_known) begin
         check("pop_delay", k, pd, (pw >= 0) ? (1 << pw) : 0);
         check("grant_idx_d", k, gid, (pw >= 0) ? pw : 0);
      end
   endtask

   always @(negedge clk) begin
      if (!done) begin
         cmp_inst(0, int'(pop0), int'(pd0), int'(gi0), int'(gid0), int'(gv0), empty);
         cmp_inst(1, int'(pop1), int'(pd1), int'(gi1), int'(gid1), int'(gv1), {1'b1, empty[2:0]});
         cmp_inst(2, int'(pop2), int'(pd2), int'(gi2), int'(gid2), int'(gv2), {1'b1, empty[2:0]});
         if (reset) prev_known = 1;
      end
   end

   task automatic drive(input logic r, input logic [3:0] e, input logic [1:0] p);
      @(posedge clk);
      #1;
      reset = r;
      empty = e;
      pause = p;
      #2;
   endtask

   initial begin
      int seq0[12];
      int seq2[12];
      int gv0_exp[8];
      int gv1_exp[8];
      errors     = 0;
      checks     = 0;
      done       = 0;
      prev_known = 0;
      for (int k = 0; k < 3; k++) begin
         m_owner[k] = 0;
         m_cnt[k]   = 0;
         m_hold[k]  = 0;
         m_prev[k]  = -1;
      end
      reset = 1'b1;
      empty = 4'b0000;
      pause = 2'b00;
      seq0    = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1};
      seq2    = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 0, 0};
      gv0_exp = '{0, 0, 0, 0, 0, 0, 1, 1};
      gv1_exp = '{0, 0, 0, 1, 1, 1, 1, 1};

      drive(1'b1, 4'b0000, 2'b00);
      check("reset grant_valid", 0, int'(gv0), 0);
      check("reset vc_pop", 1, int'(pop1), 0);

      // all VCs busy: burst-limited rotation and strict priority
      for (int c = 0; c < 12; c++) begin
         drive(1'b0, 4'b0000, 2'b00);
         check("rr seq", 0, int'(gi0), seq0[c]);
         check("rr seq", 2, int'(gi2), seq2[c]);
         check("prio pop", 1, int'(pop1), 1);
      end

      // pause for 3 cycles, then holdoff of 3 on u0; immediate resume on u1
      for (int c = 0; c < 8; c++) begin
         drive(1'b0, 4'b0000, (c < 3) ? 2'b10 : 2'b00);
         check("holdoff gv", 0, int'(gv0), gv0_exp[c]);
         check("holdoff gv", 1, int'(gv1), gv1_exp[c]);
      end

      // reset in the middle of a holdoff
      drive(1'b0, 4'b0000, 2'b01);
      drive(1'b1, 4'b0000, 2'b00);
      check("reset mid-holdoff gv", 0, int'(gv0), 0);
      drive(1'b0, 4'b0000, 2'b00);
      check("after reset gv", 0, int'(gv0), 1);
      check("after reset idx", 0, int'(gi0), 0);
      check("after reset pop_delay", 0, int'(pd0), 0);

      // all empty, then only VC2 has data
      for (int c = 0; c < 5; c++) begin
         drive(1'b0, 4'b1111, 2'b00);
         check("idle gv", 2, int'(gv2), 0);
      end
      drive(1'b0, 4'b1011, 2'b00);
      check("lone VC2 idx", 2, int'(gi2), 2);
      check("lone VC2 idx", 1, int'(gi1), 2);

      // randomized traffic, pauses and occasional reset
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] e;
         logic [1:0] p;
         logic       r;
         for (int b = 0; b < 4; b++) e[b] = ($urandom_range(0, 99) < 35);
         for (int b = 0; b < 2; b++) p[b] = ($urandom_range(0, 99) < 6);
         r = ($urandom_range(0, 199) == 0);
         drive(r, e, p);
      end

      @(posedge clk);
      #3;
      done = 1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/arb_pops_n.md
Name: arb_pops_n

Overview:
- Parametrised pop arbiter between N virtual-channel FIFOs and the downstream destination FIFOs, in the transmit-side arbiter/mux path.
- Issues at most one pop per cycle across NUM_VC source FIFOs.
- Stops all pops while any destination asserts pause, and resumes only after a programmable holdoff.
- Supports strict-priority or burst-limited round-robin selection, plus a one-cycle-delayed pop copy that drives the downstream mux select and valid.

Parameters:
- NUM_VC, 2, number of virtual-channel source FIFOs (2..16).
- NUM_DEST, 2, number of destination FIFOs providing pause (1..8).
- MODE, 0, arbitration mode: 0 = strict priority (lowest index wins); 1 = round-robin with burst limit.
- BURST, 4, MODE=1 only: maximum consecutive pops granted to one VC before rotating (1..255).
- RESUME_DLY, 0, cycles of all-pause-low required before pops resume (0..255; 0 = immediate).
- IDX_W, $clog2(NUM_VC) (minimum 1), width of grant index.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- vc_empty  in  NUM_VC  per-VC FIFO empty flag.
- dest_pause  in  NUM_DEST  per-destination pause (almost-full).
- vc_pop  out  NUM_VC  one-hot-or-zero pop to VC FIFOs; combinational.
- pop_delay  out  NUM_VC  vc_pop registered by one cycle.
- grant_idx  out  IDX_W  index of the popped VC; combinational; 0 when no pop.
- grant_valid  out  1  OR-reduction of vc_pop.
- grant_idx_d  out  IDX_W  grant_idx registered by one cycle.

Behaviour:
- Reset: while reset=1, vc_pop=0, grant_valid=0, grant_idx=0 combinationally.
- Reset: at the next edge with reset=1, pop_delay=0, grant_idx_d=0, rr_owner=0, burst_cnt=0, hold_cnt=0.
- Stall: stall = (|dest_pause) | (hold_cnt!=0). While stall=1, vc_pop=0, and the state registers rr_owner and burst_cnt hold.
- Holdoff counter:
  - Each cycle any dest_pause=1, hold_cnt loads RESUME_DLY.
  - Otherwise, if hold_cnt!=0, it decrements by 1.
  - Pops resume in the first cycle with no pause and hold_cnt==0.
  - With RESUME_DLY=0, pops resume in the same cycle pause drops.
- MODE=0 (strict priority): vc_pop has a single bit set at the lowest index i with vc_empty[i]=0. rr_owner and burst_cnt are unused and stay 0.
- MODE=1 (round-robin), owner selection:
  - The owner keeps the grant if vc_empty[rr_owner]=0 and burst_cnt<BURST.
  - Otherwise, search indices rr_owner+1, rr_owner+2, … modulo NUM_VC, and finally rr_owner itself; the first non-empty index wins.
- MODE=1 (round-robin), register update on a pop:
  - Winner equal to rr_owner: burst_cnt increments by 1.
  - Winner different from rr_owner: rr_owner takes the winner index and burst_cnt is set to 1.
- MODE=1, no pop: when not stalled and all VCs are empty, no pop occurs, and rr_owner and burst_cnt hold.
- MODE=1, burst exhausted with a single requester: if burst_cnt==BURST and rr_owner is the only non-empty VC, it wins again and burst_cnt is set to 1.
- Delayed outputs: pop_delay and grant_idx_d equal the previous cycle's vc_pop and grant_idx; latency is exactly 1 cycle.
- Invariants: at most one vc_pop bit is set per cycle, and vc_pop is never asserted on an empty VC.
- Pause at end of burst: pause rising in the same cycle the burst limit is reached gives no pop; burst_cnt stays at BURST, and rotation happens on the first unstalled cycle.
- Reset mid-burst or mid-holdoff: pops are suppressed in the same cycle, and all state clears at the edge. After release, MODE=1 search starts from index 1, because rr_owner=0 with burst_cnt=0 is treated as owner 0.
- Arithmetic: burst_cnt is 8 bits wide and saturates at BURST. hold_cnt is 8 bits wide. Index arithmetic wraps modulo NUM_VC for non-power-of-two NUM_VC.

Test Plan:
- Test 1: NUM_VC=2, MODE=0, both VCs non-empty, no pause → vc_pop=01 every cycle; pop_delay=01 from cycle 2; VC1 is popped only once vc_empty=01.
- Test 2: NUM_VC=4, MODE=1, BURST=2, all VCs non-empty for 12 cycles → grant_idx sequence 0,0,1,1,2,2,3,3,0,0,1,1.
- Test 3: MODE=1, BURST=3, VC1 non-empty and VC2 going non-empty at cycle 2 → grants 1,1,1,2,2,2,1…; an owner that goes empty mid-burst rotates immediately.
- Test 4: RESUME_DLY=3, dest_pause[1] high for cycles 5–7 → vc_pop=0 for cycles 5–10, pops resume at cycle 11, and pop_delay is 0 for cycles 6–11.
- Test 5: reset=1 asserted for 1 cycle mid-burst with holdoff active → vc_pop=0 that cycle, all counters 0 after, pop_delay=0 the next cycle.
- Test 6: NUM_VC=3, MODE=1, all VCs empty for 5 cycles then only VC2 non-empty → no pops and rr_owner held, then grant_idx=2 in the cycle VC2 becomes non-empty.
